lcd_pattern_gen: RTL and testbench

LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

---
 rtl/lcd_pattern_gen.sv | 118 +++++++++++
 tb/tb_lcd_pattern_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_pattern_gen : test-pattern pixel source answering lcd_driver requests |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module lcd_pattern_gen #(
  parameter int H_DISP         = 640,
  parameter int V_DISP         = 480,
  parameter int FRAMES_PER_PAT = 60
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        lcd_request,
  input  logic [10:0] lcd_xpos,
  input  logic [10:0] lcd_ypos,
  input  logic [2:0]  iMODE,
  input  logic        iAUTO,
  output logic [23:0] lcd_data,
  output logic [2:0]  oPATTERN,
  output logic [7:0]  oFRAME_CNT
);

  localparam int          FPP_W    = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
  localparam logic [FPP_W-1:0] FPP_LAST = FPP_W'(FRAMES_PER_PAT - 1);
  localparam logic [10:0] BAR_W    = 11'(H_DISP / 8);
  localparam logic [10:0] X_LAST   = 11'(H_DISP - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_DISP - 1);
  localparam logic [11:0] H_LIM    = 12'(H_DISP);
  localparam logic [23:0] WHITE    = 24'hFFFFFF;
  localparam logic [23:0] BLACK    = 24'h000000;
  localparam logic [23:0] RED      = 24'hFF0000;
  localparam logic [23:0] GREEN    = 24'h00FF00;
  localparam logic [23:0] BLUE     = 24'h0000FF;

  logic [10:0]      bar_x;
  logic [FPP_W-1:0] fpp_cnt;
  logic             eof;
  logic [11:0]      bar_sum;
  logic [10:0]      bar_idx;
  logic [7:0]       cnt_mod3;
  logic [23:0]      pixel;

  assign eof      = lcd_request && (lcd_xpos == X_LAST) && (lcd_ypos == Y_LAST);
  assign bar_sum  = {1'b0, bar_x} + 12'd4;
  assign bar_idx  = lcd_xpos / BAR_W;
  assign cnt_mod3 = oFRAME_CNT % 8'd3;

  // Pixel colour uses the pattern state as it stands before any EOF update.
  always_comb begin
    pixel = BLACK;
    case (oPATTERN)
      3'd0: begin
        if (bar_idx < 11'd8) begin
          case (bar_idx[2:0])
            3'd0:    pixel = WHITE;
            3'd1:    pixel = 24'hFFFF00;
            3'd2:    pixel = 24'h00FFFF;
            3'd3:    pixel = GREEN;
            3'd4:    pixel = 24'hFF00FF;
            3'd5:    pixel = RED;
            3'd6:    pixel = BLUE;
            default: pixel = BLACK;
          endcase
        end
      end
      3'd1: begin
        if ((lcd_xpos[4:0] == 5'd0) || (lcd_ypos[4:0] == 5'd0) ||
            (lcd_xpos == X_LAST) || (lcd_ypos == Y_LAST))
          pixel = WHITE;
      end
      3'd2: pixel = {lcd_xpos[9:2], lcd_xpos[9:2], lcd_xpos[9:2]};
      3'd3: pixel = (lcd_xpos[5] ^ lcd_ypos[5]) ? WHITE : BLACK;
      3'd4: begin
        if (({1'b0, lcd_xpos} >= {1'b0, bar_x}) &&
            ({1'b0, lcd_xpos} < ({1'b0, bar_x} + 12'd16)))
          pixel = WHITE;
        else
          pixel = BLUE;
      end
      3'd5: begin
        case (cnt_mod3)
          8'd0:    pixel = RED;
          8'd1:    pixel = GREEN;
          default: pixel = BLUE;
        endcase
      end
      default: pixel = BLACK;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      lcd_data   <= BLACK;
      oPATTERN   <= 3'd0;
      oFRAME_CNT <= 8'd0;
      bar_x      <= 11'd0;
      fpp_cnt    <= '0;
    end else begin
      lcd_data <= lcd_request ? pixel : BLACK;
      if (eof) begin
        oFRAME_CNT <= oFRAME_CNT + 8'd1;
        bar_x      <= (bar_sum >= H_LIM) ? 11'd0 : bar_sum[10:0];
        if (iAUTO) begin
          if (fpp_cnt == FPP_LAST) begin
            fpp_cnt  <= '0;
            oPATTERN <= (oPATTERN >= 3'd5) ? 3'd0 : oPATTERN + 3'd1;
          end else begin
            fpp_cnt <= fpp_cnt + 1'b1;
          end
        end else begin
          oPATTERN <= iMODE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_pattern_gen : randomized bench with a behavioural pixel model      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_lcd_pattern_gen;

  localparam int H   = 640;
  localparam int V   = 480;
  localparam int FPP = 2;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        lcd_request = 1'b0;
  logic [10:0] lcd_xpos = '0;
  logic [10:0] lcd_ypos = '0;
  logic [2:0]  iMODE = '0;
  logic        iAUTO = 1'b0;
  logic [23:0] lcd_data;
  logic [2:0]  oPATTERN;
  logic [7:0]  oFRAME_CNT;

  int total = 0;
  int bad   = 0;

  int m_pat, m_cnt, m_bar, m_fpp;
  logic [23:0] exp_data;

  lcd_pattern_gen #(.H_DISP(H), .V_DISP(V), .FRAMES_PER_PAT(FPP)) dut (
    .iCLK(iCLK), .iRST(iRST), .lcd_request(lcd_request),
    .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos), .iMODE(iMODE), .iAUTO(iAUTO),
    .lcd_data(lcd_data), .oPATTERN(oPATTERN), .oFRAME_CNT(oFRAME_CNT)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [23:0] ref_pixel(int pat, int x, int y, int bar, int cnt);
    int g;
    case (pat)
      0: return (x / (H / 8) < 8) ? BARS[x / (H / 8)] : 24'h000000;
      1: return ((x % 32 == 0) || (y % 32 == 0) || x == H - 1 || y == V - 1)
                ? 24'hFFFFFF : 24'h000000;
      2: begin
        g = (x / 4) % 256;
        return 24'(g * 65793);
      end
      3: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      4: return (x >= bar && x < bar + 16) ? 24'hFFFFFF : 24'h0000FF;
      5: return (cnt % 3 == 0) ? 24'hFF0000 : (cnt % 3 == 1) ? 24'h00FF00 : 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Applies one cycle of stimulus and advances the reference model.
  task automatic drive(input logic rst, input logic req, input int x, input int y,
                       input logic [2:0] mode, input logic auto_en);
    iRST = rst; lcd_request = req; lcd_xpos = x[10:0]; lcd_ypos = y[10:0];
    iMODE = mode; iAUTO = auto_en;
    @(posedge iCLK);
    #1;
    if (rst) begin
      exp_data = 24'h0; m_pat = 0; m_cnt = 0; m_bar = 0; m_fpp = 0;
    end else begin
      exp_data = req ? ref_pixel(m_pat, x, y, m_bar, m_cnt) : 24'h0;
      if (req && x == H - 1 && y == V - 1) begin
        m_cnt = (m_cnt + 1) % 256;
        m_bar = (m_bar + 4 >= H) ? 0 : m_bar + 4;
        if (auto_en) begin
          if (m_fpp == FPP - 1) begin
            m_fpp = 0;
            m_pat = (m_pat >= 5) ? 0 : m_pat + 1;
          end else begin
            m_fpp = m_fpp + 1;
          end
        end else begin
          m_pat = int'(mode);
        end
      end
    end
  endtask

  task automatic eof(input logic [2:0] mode, input logic auto_en);
    drive(1'b0, 1'b1, H - 1, V - 1, mode, auto_en);
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 5, 5, 3'd2, 1'b0);
    drive(1'b1, 1'b1, H - 1, V - 1, 3'd2, 1'b0);
    total++;
    if (lcd_data !== 24'h0) begin bad++; $display("FAIL reset_data: got %h want 000000", lcd_data); end
    total++;
    if (oPATTERN !== 3'd0) begin bad++; $display("FAIL reset_pat: got %0d want 0", oPATTERN); end
    total++;
    if (oFRAME_CNT !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", oFRAME_CNT); end
  endtask

  task automatic test_colour_bars;
    drive(1'b1, 1'b0, 0, 0, 3'd0, 1'b0);
    drive(1'b0, 1'b1, 85, 10, 3'd0, 1'b0);
    total++;
    if (lcd_data !== 24'hFFFF00) begin bad++; $display("FAIL bars_85: got %h want FFFF00", lcd_data); end
    drive(1'b0, 1'b1, 639, 10, 3'd0, 1'b0);
    total++;
    if (lcd_data !== 24'h000000) begin bad++; $display("FAIL bars_639: got %h want 000000", lcd_data); end
  endtask

  task automatic test_mode_change;
    drive(1'b1, 1'b0, 0, 0, 3'd0, 1'b0);
    drive(1'b0, 1'b1, 10, 10, 3'd3, 1'b0);
    drive(1'b0, 1'b1, 639, 478, 3'd3, 1'b0);
    total++;
    if (oPATTERN !== 3'd0) begin bad++; $display("FAIL mode_midframe: got %0d want 0", oPATTERN); end
    eof(3'd3, 1'b0);
    total++;
    if (oPATTERN !== 3'd3) begin bad++; $display("FAIL mode_after_eof: got %0d want 3", oPATTERN); end
    drive(1'b0, 1'b1, 32, 0, 3'd1, 1'b0);
    total++;
    if (lcd_data !== 24'hFFFFFF) begin bad++; $display("FAIL checker_32_0: got %h want FFFFFF", lcd_data); end
    drive(1'b0, 1'b1, 32, 32, 3'd1, 1'b0);
    total++;
    if (lcd_data !== 24'h000000) begin bad++; $display("FAIL checker_32_32: got %h want 000000", lcd_data); end
    total++;
    if (oPATTERN !== 3'd3) begin bad++; $display("FAIL mode_hold: got %0d want 3", oPATTERN); end
  endtask

  task automatic test_auto;
    int seq [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
    drive(1'b1, 1'b0, 0, 0, 3'd0, 1'b1);
    for (int f = 0; f < 12; f++) begin
      drive(1'b0, 1'b1, $urandom_range(0, H - 1), $urandom_range(0, V - 2),
            3'($urandom), 1'b1);
      total++;
      if (oPATTERN !== 3'(seq[f])) begin
        bad++; $display("FAIL auto_pat f=%0d: got %0d want %0d", f, oPATTERN, seq[f]);
      end
      total++;
      if (lcd_data !== exp_data) begin
        bad++; $display("FAIL auto_data f=%0d: got %h want %h", f, lcd_data, exp_data);
      end
      eof(3'($urandom), 1'b1);
    end
    total++;
    if (oPATTERN !== 3'd0) begin bad++; $display("FAIL auto_final_pat: got %0d want 0", oPATTERN); end
    total++;
    if (oFRAME_CNT !== 8'd12) begin bad++; $display("FAIL auto_cnt: got %0d want 12", oFRAME_CNT); end
  endtask

  task automatic test_moving_bar;
    drive(1'b1, 1'b0, 0, 0, 3'd4, 1'b0);
    for (int f = 0; f < 3; f++) eof(3'd4, 1'b0);
    drive(1'b0, 1'b1, 12, 100, 3'd4, 1'b0);
    total++;
    if (lcd_data !== 24'hFFFFFF) begin bad++; $display("FAIL bar_12: got %h want FFFFFF", lcd_data); end
    drive(1'b0, 1'b1, 28, 100, 3'd4, 1'b0);
    total++;
    if (lcd_data !== 24'h0000FF) begin bad++; $display("FAIL bar_28: got %h want 0000FF", lcd_data); end
    drive(1'b0, 1'b1, 27, 100, 3'd4, 1'b0);
    total++;
    if (lcd_data !== 24'hFFFFFF) begin bad++; $display("FAIL bar_27: got %h want FFFFFF", lcd_data); end
    drive(1'b0, 1'b1, 11, 100, 3'd4, 1'b0);
    total++;
    if (lcd_data !== 24'h0000FF) begin bad++; $display("FAIL bar_11: got %h want 0000FF", lcd_data); end
    for (int f = 3; f < 160; f++) eof(3'd4, 1'b0);
    drive(1'b0, 1'b1, 0, 5, 3'd4, 1'b0);
    total++;
    if (lcd_data !== 24'hFFFFFF) begin bad++; $display("FAIL bar_wrap_0: got %h want FFFFFF", lcd_data); end
    drive(1'b0, 1'b1, 16, 5, 3'd4, 1'b0);
    total++;
    if (lcd_data !== 24'h0000FF) begin bad++; $display("FAIL bar_wrap_16: got %h want 0000FF", lcd_data); end
  endtask

  task automatic test_request_low_and_reset;
    drive(1'b1, 1'b0, 0, 0, 3'd0, 1'b0);
    drive(1'b0, 1'b0, 85, 10, 3'd0, 1'b0);
    total++;
    if (lcd_data !== 24'h0) begin bad++; $display("FAIL req_low: got %h want 000000", lcd_data); end
    drive(1'b0, 1'b0, H - 1, V - 1, 3'd0, 1'b0);
    total++;
    if (oFRAME_CNT !== 8'd0) begin bad++; $display("FAIL req_low_eof: got %0d want 0", oFRAME_CNT); end
    eof(3'd5, 1'b0);
    eof(3'd5, 1'b0);
    drive(1'b1, 1'b1, H - 1, V - 1, 3'd5, 1'b0);
    total++;
    if (oFRAME_CNT !== 8'd0) begin bad++; $display("FAIL rst_eof_cnt: got %0d want 0", oFRAME_CNT); end
    total++;
    if (oPATTERN !== 3'd0) begin bad++; $display("FAIL rst_eof_pat: got %0d want 0", oPATTERN); end
    eof(3'd5, 1'b0);
    total++;
    if (oFRAME_CNT !== 8'd1) begin bad++; $display("FAIL first_eof_after_rst: got %0d want 1", oFRAME_CNT); end
  endtask

  task automatic test_frame_wrap;
    drive(1'b1, 1'b0, 0, 0, 3'd5, 1'b0);
    for (int f = 1; f <= 256; f++) begin
      eof(3'd5, 1'b0);
      drive(1'b0, 1'b1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 3'd5, 1'b0);
      total++;
      if (oFRAME_CNT !== 8'(f % 256)) begin
        bad++; $display("FAIL wrap_cnt f=%0d: got %0d want %0d", f, oFRAME_CNT, f % 256);
      end
      total++;
      if (lcd_data !== exp_data) begin
        bad++; $display("FAIL wrap_colour f=%0d: got %h want %h", f, lcd_data, exp_data);
      end
    end
    total++;
    if (lcd_data !== 24'hFF0000) begin bad++; $display("FAIL wrap_final_red: got %h want FF0000", lcd_data); end
  endtask

  task automatic test_back_to_back;
    int x, y;
    logic req;
    logic [2:0] mode;
    logic au;
    drive(1'b1, 1'b0, 0, 0, 3'd0, 1'b0);
    mode = 3'd0; au = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mode = 3'($urandom);
        au   = ($urandom_range(0, 3) == 0);
      end
      if (i % 37 == 36) begin
        eof(mode, au);
      end else begin
        req = ($urandom_range(0, 3) != 0);
        x   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, H - 1);
        y   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, V - 1);
        drive(1'b0, req, x, y, mode, au);
      end
      total++;
      if (lcd_data !== exp_data) begin
        bad++; $display("FAIL rand_data i=%0d: got %h want %h", i, lcd_data, exp_data);
      end
      total++;
      if (oPATTERN !== 3'(m_pat) || oFRAME_CNT !== 8'(m_cnt)) begin
        bad++; $display("FAIL rand_state i=%0d: got pat=%0d cnt=%0d want pat=%0d cnt=%0d",
                        i, oPATTERN, oFRAME_CNT, m_pat, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_colour_bars();
    test_mode_change();
    test_auto();
    test_moving_bar();
    test_request_low_and_reset();
    test_frame_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
